// File: rtl/noise_arbiter.sv
// Round-robin arbiter sharing the noise-level select `s` between requesters A and B.
// A granted level is held for DWELL cycles, then one GAP cycle returns `s` to IDLE_LEVEL before rearbitration.
module noise_arbiter #(
  parameter int unsigned DWELL      = 16,
  parameter logic [2:0]  IDLE_LEVEL = 3'b000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [2:0] lvl_a,
  input  logic       req_b,
  input  logic [2:0] lvl_b,
  output logic [2:0] s,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(DWELL - 1);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [2:0] s_nx;
  logic [1:0] grant_nx, done_nx;
  logic       last_b, last_b_nx;   // 1 when B held the most recent grant
  logic       pick_b;
  logic       owner_req;
  logic       expired;

  // On a tie, the requester that did not hold the previous grant wins.
  assign pick_b    = req_b && (!req_a || !last_b);
  assign owner_req = grant[1] ? req_b : req_a;
  assign expired   = (cnt == 8'd0);
  assign busy      = (state != IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    state_nx  = state;
    cnt_nx    = cnt;
    s_nx      = s;
    grant_nx  = grant;
    done_nx   = 2'b00;
    last_b_nx = last_b;

    unique case (state)
      IDLE: begin
        if (req_a || req_b) begin
          state_nx = HOLD;
          grant_nx = pick_b ? 2'b10 : 2'b01;
          s_nx     = pick_b ? lvl_b : lvl_a;
          cnt_nx   = CNT_LOAD;
        end
      end

      HOLD: begin
        // Expiry takes priority over an abort in the same cycle, so done still pulses.
        if (expired || !owner_req) begin
          state_nx  = GAP;
          grant_nx  = 2'b00;
          s_nx      = IDLE_LEVEL;
          cnt_nx    = 8'd0;
          done_nx   = expired ? grant : 2'b00;
          last_b_nx = grant[1];
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end

      GAP: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
        grant_nx = 2'b00;
        s_nx     = IDLE_LEVEL;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  // Reset is sampled on the clock edge and overrides everything, including an in-flight grant.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      s      <= IDLE_LEVEL;
      grant  <= 2'b00;
      done   <= 2'b00;
      last_b <= 1'b1;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      s      <= s_nx;
      grant  <= grant_nx;
      done   <= done_nx;
      last_b <= last_b_nx;
    end
  end

endmodule

// File: tb/tb_noise_arbiter.sv
// Self-checking bench for noise_arbiter: two instances (DWELL=4 and DWELL=1) share stimulus and are
// compared every cycle against a grant-episode reference model, plus directed checks from the test plan.
module tb_noise_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [2:0] lvl_a = 3'd0, lvl_b = 3'd0;

  logic [2:0] s4, s1;
  logic [1:0] grant4, grant1, done4, done1;
  logic       busy4, busy1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  noise_arbiter #(.DWELL(4), .IDLE_LEVEL(3'b000)) dut4 (
    .clk(clk), .rst(rst),
    .req_a(req_a), .lvl_a(lvl_a), .req_b(req_b), .lvl_b(lvl_b),
    .s(s4), .grant(grant4), .done(done4), .busy(busy4)
  );

  noise_arbiter #(.DWELL(1), .IDLE_LEVEL(3'b000)) dut1 (
    .clk(clk), .rst(rst),
    .req_a(req_a), .lvl_a(lvl_a), .req_b(req_b), .lvl_b(lvl_b),
    .s(s1), .grant(grant1), .done(done1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each instance is either holding a grant (owner 0=A, 1=B) for a number of
  // cycles, sitting in its one-cycle gap, or idle.
  int         dwell [2] = '{4, 1};
  int         owner [2];
  int         held  [2];
  int         last  [2];
  bit         gap   [2];
  logic [2:0] level [2];
  logic [1:0] mdone [2];

  task automatic model_step(input int k);
    bit r [2];
    r[0] = req_a;
    r[1] = req_b;
    mdone[k] = 2'b00;
    if (!rst) begin
      owner[k] = -1;
      held[k]  = 0;
      gap[k]   = 1'b0;
      last[k]  = 1;
    end else if (owner[k] >= 0) begin
      if (held[k] == dwell[k] || !r[owner[k]]) begin
        if (held[k] == dwell[k]) mdone[k] = 2'(1 << owner[k]);
        last[k]  = owner[k];
        owner[k] = -1;
        gap[k]   = 1'b1;
      end else begin
        held[k]++;
      end
    end else if (gap[k]) begin
      gap[k] = 1'b0;
    end else if (r[0] || r[1]) begin
      owner[k] = (r[0] && r[1]) ? 1 - last[k] : (r[1] ? 1 : 0);
      level[k] = (owner[k] == 1) ? lvl_b : lvl_a;
      held[k]  = 1;
    end
  endtask

  task automatic compare(input int k, input string nm, input logic [2:0] so,
                         input logic [1:0] g, input logic [1:0] d, input logic b);
    logic [1:0] eg;
    logic [2:0] es;
    logic       bad;
    eg  = (owner[k] >= 0) ? 2'(1 << owner[k]) : 2'b00;
    es  = (owner[k] >= 0) ? level[k] : 3'b000;
    bad = (g == 2'b11) || ((g & d) != 2'b00) || ((g == 2'b00) && (so != 3'b000));
    check({nm, ".grant"}, 8'(g), 8'(eg));
    check({nm, ".s"},     8'(so), 8'(es));
    check({nm, ".done"},  8'(d), 8'(mdone[k]));
    check({nm, ".busy"},  8'(b), 8'((owner[k] >= 0) || gap[k]));
    check({nm, ".invariant"}, 8'(bad), 8'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare(0, "d4", s4, grant4, done4, busy4);
    compare(1, "d1", s1, grant1, done1, busy1);
  endtask

  initial begin
    // Reset then idle
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (10) tick();

    // Single grant, DWELL=4
    lvl_a = 3'b101;
    req_a = 1'b1;
    tick();
    check("single.grant", 8'(grant4), 8'h01);
    check("single.s", 8'(s4), 8'h05);
    repeat (3) tick();
    check("single.last_hold", 8'(grant4), 8'h01);
    tick();
    check("single.done", 8'(done4), 8'h01);
    check("single.grant_off", 8'(grant4), 8'h00);
    req_a = 1'b0;
    tick();
    check("single.busy_low", 8'(busy4), 8'h00);
    check("single.done_clear", 8'(done4), 8'h00);

    // Round-robin with both requests held
    lvl_a = 3'd3;
    lvl_b = 3'd6;
    req_a = 1'b1;
    req_b = 1'b1;
    repeat (30) tick();
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (6) tick();

    // Abort on the second HOLD cycle, then a tie goes to B
    req_a = 1'b1;
    tick();
    tick();
    req_a = 1'b0;
    req_b = 1'b1;
    tick();
    check("abort.grant", 8'(grant4), 8'h00);
    check("abort.done", 8'(done4), 8'h00);
    req_a = 1'b1;
    tick();
    tick();
    check("abort.tie_to_b", 8'(grant4), 8'h02);
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (8) tick();

    // Level change and other request ignored during HOLD
    lvl_a = 3'b001;
    req_a = 1'b1;
    tick();
    lvl_a = 3'b110;
    req_b = 1'b1;
    tick();
    req_b = 1'b0;
    tick();
    check("lvlchg.s", 8'(s4), 8'h01);
    check("lvlchg.grant", 8'(grant4), 8'h01);
    repeat (3) tick();
    req_a = 1'b0;
    repeat (4) tick();

    // Reset mid-HOLD, then A wins the first tie
    req_a = 1'b1;
    req_b = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rsthold.grant", 8'(grant4), 8'h00);
    check("rsthold.done", 8'(done4), 8'h00);
    rst = 1'b1;
    tick();
    check("rsthold.first_a", 8'(grant4), 8'h01);

    // Randomized traffic with occasional resets
    repeat (3000) begin
      rst   = ($urandom_range(0, 99) != 0);
      req_a = ($urandom_range(0, 7) == 0) ? ~req_a : req_a;
      req_b = ($urandom_range(0, 7) == 0) ? ~req_b : req_b;
      lvl_a = 3'($urandom_range(0, 7));
      lvl_b = 3'($urandom_range(0, 7));
      tick();
    end

    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (8) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/noise_arbiter.md
Name: noise_arbiter

Overview:
- Shares the single noise-level resource (the 3-bit level select `s` driving the 7-bit noise indicator) between two requesters, A and B.
- Each requester asks for a level. The arbiter grants one requester at a time, round-robin, and drives that requester's level onto `s` for a fixed dwell time.
- It then returns `s` to an idle level, pulses completion to the requester, and rearbitrates.
- Sits directly upstream of the noise level decoder.

Parameters:
- DWELL, 16, number of clock cycles a granted level is held on `s`; legal range 1..255, counter is 8 bits.
- IDLE_LEVEL, 3'b000, value driven on `s` whenever no requester holds the grant.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous active-low reset; 0 on a rising clk edge resets the block.
- req_a  input  1  requester A request, level-sensitive.
- lvl_a  input  3  requester A desired level.
- req_b  input  1  requester B request, level-sensitive.
- lvl_b  input  3  requester B desired level.
- s  output  3  level select to the noise decoder, registered.
- grant  output  2  one-hot grant, bit0=A, bit1=B, registered.
- done  output  2  one-cycle completion pulse, bit0=A, bit1=B.
- busy  output  1  high while state is not IDLE.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, s=IDLE_LEVEL, grant=2'b00, done=2'b00, busy=0, dwell counter=0.
  - Round-robin pointer set so A wins the first tie.
  - Reset overrides every other input in that cycle, including mid-HOLD: no done pulse is issued for an aborted grant.
- States: IDLE, HOLD, GAP.
- IDLE:
  - If neither request is high, stay in IDLE; outputs stay at their idle values.
  - If exactly one request is high, grant that requester.
  - If both are high, grant the requester that was not granted most recently; after reset, A is granted.
  - On grant, at the next edge: latch that requester's lvl into `s`, set the matching grant bit, load counter=DWELL-1, busy=1, go to HOLD.
  - Latency: request seen high at edge N gives grant/s valid after edge N+1 (one cycle).
- HOLD:
  - grant and `s` are stable. Changes on lvl_a/lvl_b or on the other requester's req are ignored.
  - Counter decrements by 1 each cycle.
  - When counter==0 at an edge: go to GAP, grant=0, s=IDLE_LEVEL, pulse done bit for the granted requester, update the round-robin pointer to that requester.
  - Result: grant is high for exactly DWELL cycles; DWELL=1 gives a one-cycle grant.
  - Abort: if the granted requester's req is low at an edge during HOLD, go to GAP immediately with grant=0 and s=IDLE_LEVEL. No done pulse is issued, but the pointer is still updated.
  - If abort and counter==0 occur in the same cycle, completion wins: done pulses.
- GAP:
  - Lasts one cycle. grant=0, s=IDLE_LEVEL, busy=1, done pulse visible (completion case only).
  - Next edge: go to IDLE, busy=0, done=0.
  - Requests are not sampled in GAP.
  - Minimum spacing between the falling edge of one grant and the rising edge of the next is 2 cycles (GAP, then IDLE sampling).
- Invariants:
  - grant is never 2'b11.
  - done is never asserted together with a set grant bit.
  - `s` equals IDLE_LEVEL whenever grant==0.
- Requester obligation: a requester keeps req high until it sees its done bit (or abandons by dropping req). A req still high after done is treated as a new request at the next IDLE.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then rst=1, no requests for 10 cycles -> s=3'b000, grant=00, done=00, busy=0 throughout.
- Single grant: DWELL=4, req_a=1 with lvl_a=3'b101 sampled at edge N -> grant=01 and s=101 during edges N+1..N+4; at N+5 grant=00, s=000, done=01 for one cycle; busy low from N+6.
- Round-robin: both req held high with lvl_a=3, lvl_b=6 -> grants alternate A, B, A, B, with s=3, 6, 3, 6; each grant lasts DWELL cycles; 2-cycle gaps between grants.
- Abort: A granted, req_a dropped on the 2nd HOLD cycle -> next edge grant=00, s=IDLE_LEVEL, done=00; the next tie with B pending is granted to B.
- Level change ignored: during A's HOLD, toggle lvl_a 3'b001 to 3'b110 and pulse req_b -> s keeps the latched value and grant stays 01 until dwell expiry.
- Reset mid-HOLD: rst=0 on the 3rd HOLD cycle -> next edge all outputs at reset values, no done pulse; with both requests held high after rst=1, A is granted first.
